// File: rtl/mcs4_seq_pkg.sv
// Shared types for the i4004 two-phase clock / POC sequencer: FSM states, slots and phases.
package mcs4_seq_pkg;

  typedef enum logic [1:0] {
    StPocHold = 2'd0,
    StRun     = 2'd1,
    StHalt    = 2'd2,
    StStep    = 2'd3
  } seq_state_e;

  // Four slots per phase: clk1 pulse, gap, clk2 pulse, gap.
  typedef enum logic [1:0] {
    SlotS0 = 2'd0,
    SlotS1 = 2'd1,
    SlotS2 = 2'd2,
    SlotS3 = 2'd3
  } slot_e;

  typedef enum logic [2:0] {
    PhA1 = 3'd0,
    PhA2 = 3'd1,
    PhA3 = 3'd2,
    PhM1 = 3'd3,
    PhM2 = 3'd4,
    PhX1 = 3'd5,
    PhX2 = 3'd6,
    PhX3 = 3'd7
  } phase_e;

endpackage

// File: rtl/mcs4_slot_divider.sv
// Slot-length counter: slot_tick_o marks the last clk of each slot (div_sel_i + 1 clks long).
module mcs4_slot_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ena_i,
  input  logic             hold_i,
  input  logic [DIV_W-1:0] div_sel_i,
  output logic             slot_tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] len_q, len_d;
  logic [DIV_W-1:0] len;

  // div_sel_i is only looked at on the first clk of a slot; later clks use the latched copy.
  assign len = (cnt_q == '0) ? div_sel_i : len_q;

  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    slot_tick_o = 1'b0;
    if (ena_i) begin
      if (hold_i) begin
        cnt_d = '0;
      end else begin
        slot_tick_o = (cnt_q == len);
        cnt_d       = slot_tick_o ? '0 : cnt_q + 1'b1;
        len_d       = len;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/mcs4_phase_sequencer.sv
// Two-phase clock, 8-phase instruction-cycle and POC sequencer for the i4004 core.
// Optional SYNC phase check is enabled by defining MCS4_SYNC_CHECK_EN.
module mcs4_phase_sequencer
  import mcs4_seq_pkg::*;
#(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned POC_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [DIV_W-1:0] div_sel,
  input  logic             run,
  input  logic             step_req,
  input  logic             soft_poc,
  input  logic             sync_in,
  output logic             clk1,
  output logic             clk2,
  output logic             poc,
  output logic [2:0]       phase,
  output logic             cycle_end,
  output logic             halted,
  output logic             step_ack,
  output logic             sync_err
);

  localparam logic [7:0] PocLast = 8'(POC_CYCLES - 1);

  seq_state_e state_q, state_d;
  slot_e      slot_q, slot_d;
  phase_e     phase_q, phase_d;
  logic       poc_q, poc_d;
  logic [7:0] poc_cnt_q, poc_cnt_d;
  logic       clk1_q, clk1_d;
  logic       clk2_q, clk2_d;
  logic       slot_tick;
  logic       cyc_last;

  mcs4_slot_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ena_i      (ena),
    .hold_i     (state_q == StHalt),
    .div_sel_i  (div_sel),
    .slot_tick_o(slot_tick)
  );

  // slot_tick is already gated by ena and by the HALT hold.
  assign cyc_last = slot_tick && (slot_q == SlotS3) && (phase_q == PhX3);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    phase_d   = phase_q;
    poc_d     = poc_q;
    poc_cnt_d = poc_cnt_q;
    clk1_d    = clk1_q;
    clk2_d    = clk2_q;
    if (ena) begin
      if (slot_tick) begin
        slot_d = slot_e'(slot_q + 2'd1);
        if (slot_q == SlotS3) phase_d = phase_e'(phase_q + 3'd1);
      end
      unique case (state_q)
        StPocHold: begin
          if (cyc_last) begin
            if (poc_cnt_q == PocLast) begin
              poc_d   = 1'b0;
              state_d = run ? StRun : StHalt;
            end else begin
              poc_cnt_d = poc_cnt_q + 8'd1;
            end
          end
        end
        StRun:  if (cyc_last && !run) state_d = StHalt;
        StHalt: begin
          if (step_req)  state_d = StStep;
          else if (run)  state_d = StRun;
        end
        StStep: if (cyc_last) state_d = StHalt;
      endcase
      if (soft_poc) begin
        state_d   = StPocHold;
        poc_d     = 1'b1;
        poc_cnt_d = '0;
      end
      // Clocks are registered from the next slot so they line up with slot_q.
      clk1_d = (state_d != StHalt) && (slot_d == SlotS0);
      clk2_d = (state_d != StHalt) && (slot_d == SlotS2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPocHold;
      slot_q    <= SlotS0;
      phase_q   <= PhA1;
      poc_q     <= 1'b1;
      poc_cnt_q <= '0;
      clk1_q    <= 1'b0;
      clk2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      phase_q   <= phase_d;
      poc_q     <= poc_d;
      poc_cnt_q <= poc_cnt_d;
      clk1_q    <= clk1_d;
      clk2_q    <= clk2_d;
    end
  end

  assign clk1      = clk1_q;
  assign clk2      = clk2_q;
  assign poc       = poc_q;
  assign phase     = phase_q;
  assign cycle_end = cyc_last;
  assign halted    = (state_q == StHalt);
  assign step_ack  = cyc_last && (state_q == StStep);

`ifdef MCS4_SYNC_CHECK_EN
  logic sync_err_q, sync_err_d;

  // SYNC must be high exactly at the close of X3.
  always_comb begin
    sync_err_d = sync_err_q;
    if (ena) begin
      if (slot_tick && (slot_q == SlotS3) && (state_q == StRun || state_q == StStep) &&
          (sync_in != (phase_q == PhX3))) begin
        sync_err_d = 1'b1;
      end
      if (soft_poc) sync_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_err_q <= 1'b0;
    else        sync_err_q <= sync_err_d;
  end

  assign sync_err = sync_err_q;
`else
  logic unused_sync_in;
  assign unused_sync_in = sync_in;
  assign sync_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mcs4_phase_sequencer.sv
// Scoreboard bench: stimulus queues one record per expected cycle_end; a monitor checks them.
module tb_mcs4_phase_sequencer;

`ifdef MCS4_SYNC_CHECK_EN
  localparam logic SyncChk = 1'b1;
`else
  localparam logic SyncChk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] div_sel = 8'd0;
  logic       run = 1'b1;
  logic       step_req = 1'b0;
  logic       soft_poc = 1'b0;
  logic       sync_force = 1'b0;
  logic       sync_in;
  logic       clk1, clk2, poc, cycle_end, halted, step_ack, sync_err;
  logic [2:0] phase;

  typedef struct packed {
    logic        poc;
    logic        ack;
    logic [15:0] period;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;

  always #5 clk = ~clk;

  // Behaves like the core: SYNC high during X3 unless forced.
  assign sync_in = sync_force | (phase == 3'd7);

  mcs4_phase_sequencer #(
    .DIV_W     (8),
    .POC_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .div_sel  (div_sel),
    .run      (run),
    .step_req (step_req),
    .soft_poc (soft_poc),
    .sync_in  (sync_in),
    .clk1     (clk1),
    .clk2     (clk2),
    .poc      (poc),
    .phase    (phase),
    .cycle_end(cycle_end),
    .halted   (halted),
    .step_ack (step_ack),
    .sync_err (sync_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic p, input logic a, input int per, input int n);
    rec_t r;
    r.poc    = p;
    r.ack    = a;
    r.period = 16'(per);
    repeat (n) exp_q.push_back(r);
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: ncyc counts clocking clks (enabled, not halted) since the previous cycle_end.
  always @(negedge clk) begin
    if (!rst_n) begin
      ncyc = 0;
    end else begin
      if (ena && !halted) ncyc++;
      chk("no_overlap", {31'd0, clk1 & clk2}, 32'd0);
      if (cycle_end) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cycle_end: got cycle_end=1 expected none at %0t", $time);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          chk("ce_poc", {31'd0, poc}, {31'd0, r.poc});
          chk("ce_step_ack", {31'd0, step_ack}, {31'd0, r.ack});
          chk("ce_period", ncyc, {16'd0, r.period});
        end
        ncyc = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_clk1", clk1, 0);
    chk("rst_clk2", clk2, 0);
    chk("rst_poc", poc, 1);
    chk("rst_phase", phase, 0);
    chk("rst_cycle_end", cycle_end, 0);
    chk("rst_halted", halted, 0);
    chk("rst_step_ack", step_ack, 0);
    chk("rst_sync_err", sync_err, 0);

    // POC hold with div_sel=0: 16 cycles of 32 clks, clk1/clk2 on slots 0/2
    push(1'b1, 1'b0, 32, 16);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 1; n <= 512; n++) begin
      edges(1);
      chk("s1_clk1", clk1, ((n % 4) == 0) ? 1 : 0);
      chk("s1_clk2", clk2, ((n % 4) == 2) ? 1 : 0);
      chk("s1_phase", phase, (n / 4) % 8);
      if (n == 511) chk("s1_poc_held", poc, 1);
      if (n == 512) begin
        chk("s1_poc_drop", poc, 0);
        chk("s1_run_state", halted, 0);
      end
    end

    // div_sel=3: 4-clk slots, 16-clk phases, 128-clk cycles
    div_sel = 8'd3;
    push(1'b0, 1'b0, 128, 2);
    for (int k = 1; k <= 256; k++) begin
      edges(1);
      chk("s2_phase", phase, (k / 16) % 8);
      chk("s2_clk1", clk1, ((k % 16) < 4) ? 1 : 0);
      chk("s2_clk2", clk2, ((k % 16) >= 8 && (k % 16) < 12) ? 1 : 0);
    end

    // Drop run at a cycle boundary: one more cycle, then HALT
    run = 1'b0;
    div_sel = 8'd0;
    push(1'b0, 1'b0, 32, 1);
    edges(31);
    chk("s3_not_yet_halted", halted, 0);
    edges(1);
    chk("s3_halted", halted, 1);
    chk("s3_halt_clk1", clk1, 0);
    chk("s3_halt_phase", phase, 0);

    // Three single steps, 200 clks apart
    for (int s = 0; s < 3; s++) begin
      push(1'b0, 1'b1, 32, 1);
      step_req = 1'b1;
      edges(1);
      step_req = 1'b0;
      chk("step_started", halted, 0);
      chk("step_clk1", clk1, 1);
      edges(31);
      chk("step_running", halted, 0);
      edges(1);
      chk("step_rehalted", halted, 1);
      edges(167);
    end

    // RUN with an ena freeze, then run dropped at phase 3 with a stray step_req
    push(1'b0, 1'b0, 32, 1);
    run = 1'b1;
    edges(1);
    chk("s4_running", halted, 0);
    edges(6);
    chk("s4_phase1", phase, 1);
    chk("s4_clk2", clk2, 1);
    ena = 1'b0;
    edges(10);
    chk("s4_frozen_phase", phase, 1);
    chk("s4_frozen_clk2", clk2, 1);
    chk("s4_frozen_clk1", clk1, 0);
    ena = 1'b1;
    edges(6);
    chk("s4_phase3", phase, 3);
    run = 1'b0;
    step_req = 1'b1;
    edges(1);
    step_req = 1'b0;
    edges(18);
    chk("s4_cycle_end", cycle_end, 1);
    chk("s4_phase7", phase, 7);
    chk("s4_still_running", halted, 0);
    edges(1);
    chk("s4_halted", halted, 1);
    edges(50);
    chk("s4_step_ignored", halted, 1);

    // step_req while ena=0 is dropped
    ena = 1'b0;
    step_req = 1'b1;
    edges(1);
    step_req = 1'b0;
    ena = 1'b1;
    edges(40);
    chk("s4_ena_drop", halted, 1);

    // soft_poc and step_req together while halted: soft_poc wins
    push(1'b1, 1'b0, 32, 16);
    soft_poc = 1'b1;
    step_req = 1'b1;
    edges(1);
    soft_poc = 1'b0;
    step_req = 1'b0;
    chk("s5_poc", poc, 1);
    chk("s5_restart", halted, 0);
    chk("s5_clk1", clk1, 1);
    edges(511);
    chk("s5_poc_held", poc, 1);
    edges(1);
    chk("s5_poc_drop", poc, 0);
    chk("s5_halted", halted, 1);

    // SYNC forced high through phase 3 in RUN
    sync_force = 1'b1;
    push(1'b0, 1'b0, 32, 1);
    run = 1'b1;
    edges(17);
    chk("s6_phase4", phase, 4);
    sync_force = 1'b0;
    run = 1'b0;
    chk("s6_sync_err", sync_err, SyncChk);
    edges(16);
    chk("s6_halted", halted, 1);
    chk("s6_sync_sticky", sync_err, SyncChk);
    push(1'b1, 1'b0, 32, 16);
    soft_poc = 1'b1;
    edges(1);
    soft_poc = 1'b0;
    chk("s6_sync_cleared", sync_err, 0);
    chk("s6_poc", poc, 1);
    edges(512);
    chk("s6_poc_drop", poc, 0);
    chk("s6_halted_again", halted, 1);

    // Asynchronous reset mid-cycle
    run = 1'b1;
    edges(11);
    chk("s7_phase2", phase, 2);
    rst_n = 1'b0;
    #1;
    chk("s7_rst_poc", poc, 1);
    chk("s7_rst_phase", phase, 0);
    chk("s7_rst_clk1", clk1, 0);
    chk("s7_rst_clk2", clk2, 0);
    chk("s7_rst_halted", halted, 0);
    chk("s7_rst_sync_err", sync_err, 0);
    edges(2);
    chk("pending_records", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
